// File: rtl/residue_check_unit_pkg.sv
// residue_check_unit_pkg
//   Shared constants, op encoding and state type for the mod-31 residue checker.
//   No ports; imported by residue_check_unit and mersenne_fold.
package residue_check_unit_pkg;

  // Width of each half of the checked ALU result.
  localparam int WIDTH    = 32;

  // Residue width and the Mersenne modulus 2^MOD_BITS-1.
  localparam int MOD_BITS = 5;
  localparam int MERSENNE = 31;

  // Number of MOD_BITS-wide chunks needed to cover the 2*WIDTH-bit result.
  localparam int NCHUNK   = 13;
  localparam int CNT_BITS = 4;

  // Operation encoding on in_op.
  localparam logic OP_ADD  = 1'b0;
  localparam logic OP_MULT = 1'b1;

  // Controller states: waiting for work, folding chunks, presenting result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FOLD = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mersenne_fold.sv
// mersenne_fold
//   Combinational end-around-carry reduction of a value of up to 2*MOD_BITS
//   bits to its normalized residue modulo 2^MOD_BITS-1 (result in 0..30).
// Ports:
//   x_i    in   2*MOD_BITS  value to reduce
//   res_o  out  MOD_BITS    normalized residue of x_i
module mersenne_fold
  import residue_check_unit_pkg::*;
(
  input  logic [2*MOD_BITS-1:0] x_i,
  output logic [MOD_BITS-1:0]   res_o
);

  logic [MOD_BITS:0]   sum1;
  logic [MOD_BITS-1:0] sum2;

  // Two end-around-carry passes are always enough: the first sum is at most
  // 62, and adding its carry back into the low bits cannot overflow again.
  // The all-ones pattern is the second encoding of zero and is mapped to 0.
  always_comb begin
    sum1  = {1'b0, x_i[MOD_BITS-1:0]} + {1'b0, x_i[2*MOD_BITS-1:MOD_BITS]};
    sum2  = sum1[MOD_BITS-1:0] + MOD_BITS'(sum1[MOD_BITS]);
    res_o = (sum2 == MOD_BITS'(MERSENNE)) ? '0 : sum2;
  end

endmodule

// File: rtl/residue_check_unit.sv
// residue_check_unit
//   Checker end of the mod-31 residue scheme. Accepts operand residues and a
//   raw 64-bit ALU result, folds the result serially (one 5-bit chunk per
//   cycle, 13 cycles) into its residue, predicts the residue from the operand
//   residues and flags any mismatch.
// Ports:
//   clock, reset       rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready  request handshake (in_ready only in IDLE)
//   in_op              0 = ADD, 1 = MULT
//   in_a_res/in_b_res  operand residues (31 accepted as 0)
//   in_result_lo/hi    checked value {hi, lo}
//   out_valid/ready    result handshake; outputs hold while out_ready = 0
//   out_error          residue mismatch
//   out_residue        normalized residue of the result
//   out_expected       normalized predicted residue
//   err_count          (only with RESCHK_ERR_COUNT_EN) saturating count of
//                      delivered results with out_error set
// Configuration macro: RESCHK_ERR_COUNT_EN
module residue_check_unit
  import residue_check_unit_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_op,
  input  logic [MOD_BITS-1:0] in_a_res,
  input  logic [MOD_BITS-1:0] in_b_res,
  input  logic [WIDTH-1:0]    in_result_lo,
  input  logic [WIDTH-1:0]    in_result_hi,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_error,
  output logic [MOD_BITS-1:0] out_residue,
  output logic [MOD_BITS-1:0] out_expected
`ifdef RESCHK_ERR_COUNT_EN
  ,
  output logic [15:0]         err_count
`endif
);

  localparam logic [CNT_BITS-1:0] LAST_CHUNK = CNT_BITS'(NCHUNK - 1);

  state_e                state_q, state_d;
  logic [2*WIDTH-1:0]    sr_q, sr_d;
  logic [MOD_BITS-1:0]   acc_q, acc_d;
  logic [MOD_BITS-1:0]   exp_q, exp_d;
  logic [CNT_BITS-1:0]   cnt_q, cnt_d;

  logic [2*MOD_BITS-1:0] accSum;
  logic [MOD_BITS-1:0]   accFold;
  logic [2*MOD_BITS-1:0] expRaw;
  logic [MOD_BITS-1:0]   expFold;

  // Operand widening for the two reductions. The accumulator is at most 30
  // and a chunk at most 31, and the operand product is at most 961, so both
  // raw values fit in 10 bits without loss.
  always_comb begin
    accSum = {{MOD_BITS{1'b0}}, acc_q} + {{MOD_BITS{1'b0}}, sr_q[MOD_BITS-1:0]};
    if (in_op == OP_MULT) begin
      expRaw = {{MOD_BITS{1'b0}}, in_a_res} * {{MOD_BITS{1'b0}}, in_b_res};
    end else begin
      expRaw = {{MOD_BITS{1'b0}}, in_a_res} + {{MOD_BITS{1'b0}}, in_b_res};
    end
  end

  mersenne_fold u_accFold (
    .x_i   (accSum),
    .res_o (accFold)
  );

  mersenne_fold u_expFold (
    .x_i   (expRaw),
    .res_o (expFold)
  );

  // State and datapath registers. Reset clears everything so an interrupted
  // transaction leaves no trace.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sr_q    <= '0;
      acc_q   <= '0;
      exp_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      acc_q   <= acc_d;
      exp_q   <= exp_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and output decode. Outputs are driven only in DONE so they
  // read as zero everywhere else, including straight after reset.
  always_comb begin
    state_d      = state_q;
    sr_d         = sr_q;
    acc_d        = acc_q;
    exp_d        = exp_q;
    cnt_d        = cnt_q;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    out_error    = 1'b0;
    out_residue  = '0;
    out_expected = '0;

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          sr_d    = {in_result_hi, in_result_lo};
          acc_d   = '0;
          cnt_d   = '0;
          exp_d   = expFold;
          state_d = FOLD;
        end
      end

      FOLD: begin
        acc_d = accFold;
        sr_d  = sr_q >> MOD_BITS;
        cnt_d = cnt_q + CNT_BITS'(1);
        if (cnt_q == LAST_CHUNK) begin
          state_d = DONE;
        end
      end

      DONE: begin
        out_valid    = 1'b1;
        out_residue  = acc_q;
        out_expected = exp_q;
        out_error    = (acc_q != exp_q);
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifdef RESCHK_ERR_COUNT_EN
  logic [15:0] errCnt_q;

  // Counts delivered mismatches and sticks at all-ones instead of wrapping.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      errCnt_q <= '0;
    end else if (out_valid && out_ready && out_error && (errCnt_q != 16'hFFFF)) begin
      errCnt_q <= errCnt_q + 16'd1;
    end
  end

  assign err_count = errCnt_q;
`endif

endmodule

// File: tb/tb_residue_check_unit.sv
// tb_residue_check_unit
//   Self-checking bench for residue_check_unit: directed vector table,
//   randomized transactions against an arithmetic reference model, and
//   hand-written backpressure and mid-fold reset sequences.
//   Honors RESCHK_ERR_COUNT_EN when defined.
module tb_residue_check_unit;

  typedef struct {
    logic        op;
    logic [4:0]  a;
    logic [4:0]  b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [4:0]  expRes;
    logic [4:0]  expExp;
    logic        expErr;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        in_op;
  logic [4:0]  in_a_res;
  logic [4:0]  in_b_res;
  logic [31:0] in_result_lo;
  logic [31:0] in_result_hi;
  logic        out_valid;
  logic        out_ready;
  logic        out_error;
  logic [4:0]  out_residue;
  logic [4:0]  out_expected;
`ifdef RESCHK_ERR_COUNT_EN
  logic [15:0] err_count;
`endif

  int total = 0;
  int bad = 0;
  int errModel = 0;

  residue_check_unit dut (
    .clock        (clock),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_op        (in_op),
    .in_a_res     (in_a_res),
    .in_b_res     (in_b_res),
    .in_result_lo (in_result_lo),
    .in_result_hi (in_result_hi),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_error    (out_error),
    .out_residue  (out_residue),
    .out_expected (out_expected)
`ifdef RESCHK_ERR_COUNT_EN
    ,
    .err_count    (err_count)
`endif
  );

  // Free-running clock, 10 time-unit period.
  always #5 clock = ~clock;

  // Reference: residue of the full 64-bit value by plain modulo.
  function automatic logic [4:0] modelResidue(input logic [31:0] hi, input logic [31:0] lo);
    logic [63:0] v;
    v = {hi, lo};
    return 5'(v % 64'd31);
  endfunction

  // Reference: predicted residue from the operand residues.
  function automatic logic [4:0] modelExpected(input logic op, input logic [4:0] a, input logic [4:0] b);
    int ai;
    int bi;
    ai = int'(a) % 31;
    bi = int'(b) % 31;
    if (op) return 5'((ai * bi) % 31);
    return 5'((ai + bi) % 31);
  endfunction

  // Single comparison point: counts every check and reports failures.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Drives one request, waits for acceptance and then for out_valid.
  // Returns the number of edges from the accept edge to out_valid.
  task automatic applyStimulus(input logic op, input logic [4:0] a, input logic [4:0] b,
                               input logic [31:0] hi, input logic [31:0] lo, output int lat);
    int n;
    @(negedge clock);
    in_op        = op;
    in_a_res     = a;
    in_b_res     = b;
    in_result_hi = hi;
    in_result_lo = lo;
    in_valid     = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (n >= 50) checkOutput("accept_timeout", 32'd0, 32'd1);
    @(posedge clock);
    #1;
    in_valid     = 1'b0;
    in_result_lo = $urandom;
    in_result_hi = $urandom;
    in_a_res     = 5'($urandom);
    in_b_res     = 5'($urandom);
    checkOutput("busy_in_ready", 32'(in_ready), 32'd0);
    lat = 0;
    while (!out_valid && lat < 30) begin
      @(posedge clock);
      #1;
      lat++;
    end
  endtask

  // Full transaction with out_ready high: latency, outputs, then handshake.
  task automatic runCheck(input vec_t v);
    int lat;
    out_ready = 1'b1;
    applyStimulus(v.op, v.a, v.b, v.hi, v.lo, lat);
    checkOutput("latency", 32'(lat), 32'd13);
    checkOutput("out_valid", 32'(out_valid), 32'd1);
    checkOutput("out_residue", 32'(out_residue), 32'(v.expRes));
    checkOutput("out_expected", 32'(out_expected), 32'(v.expExp));
    checkOutput("out_error", 32'(out_error), 32'(v.expErr));
    if (v.expErr) errModel++;
    @(posedge clock);
    #1;
    checkOutput("pop_out_valid", 32'(out_valid), 32'd0);
    checkOutput("pop_in_ready", 32'(in_ready), 32'd1);
  endtask

  vec_t vecs[4];

  initial begin
    vec_t rv;
    logic [31:0] opA;
    logic [31:0] opB;
    logic [63:0] full;
    int lat;
    int seen;

    vecs[0] = '{op: 1'b0, a: 5'd7,  b: 5'd9, hi: 32'd0, lo: 32'd16,
                expRes: 5'd16, expExp: 5'd16, expErr: 1'b0};
    vecs[1] = '{op: 1'b0, a: 5'd7,  b: 5'd9, hi: 32'd0, lo: 32'd17,
                expRes: 5'd17, expExp: 5'd16, expErr: 1'b1};
    vecs[2] = '{op: 1'b1, a: 5'd3,  b: 5'd2, hi: 32'd1, lo: 32'hFFFF_FFFE,
                expRes: 5'd6, expExp: 5'd6, expErr: 1'b0};
    vecs[3] = '{op: 1'b0, a: 5'd31, b: 5'd0, hi: 32'd0, lo: 32'd62,
                expRes: 5'd0, expExp: 5'd0, expErr: 1'b0};

    reset        = 1'b1;
    in_valid     = 1'b0;
    in_op        = 1'b0;
    in_a_res     = '0;
    in_b_res     = '0;
    in_result_lo = '0;
    in_result_hi = '0;
    out_ready    = 1'b1;
    #1;
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_out_error", 32'(out_error), 32'd0);
    checkOutput("reset_out_residue", 32'(out_residue), 32'd0);
    checkOutput("reset_out_expected", 32'(out_expected), 32'd0);
`ifdef RESCHK_ERR_COUNT_EN
    checkOutput("reset_err_count", 32'(err_count), 32'd0);
`endif
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;

    // Directed table.
    for (int i = 0; i < 4; i++) begin
      runCheck(vecs[i]);
`ifdef RESCHK_ERR_COUNT_EN
      if (i == 1) checkOutput("err_count_after_fault", 32'(err_count), 32'd1);
`endif
    end

    // Randomized transactions against the arithmetic model.
    for (int i = 0; i < 24; i++) begin
      opA = $urandom;
      opB = $urandom;
      rv.op = 1'($urandom_range(0, 1));
      if (rv.op) full = {32'd0, opA} * {32'd0, opB};
      else       full = {32'd0, opA} + {32'd0, opB};
      rv.a = 5'(opA % 31);
      rv.b = 5'(opB % 31);
      if (rv.a == 5'd0 && $urandom_range(0, 1) == 1) rv.a = 5'd31;
      if ($urandom_range(0, 3) == 0) full[$urandom_range(0, 63)] ^= 1'b1;
      rv.hi = full[63:32];
      rv.lo = full[31:0];
      rv.expRes = modelResidue(rv.hi, rv.lo);
      rv.expExp = modelExpected(rv.op, rv.a, rv.b);
      rv.expErr = (rv.expRes != rv.expExp);
      runCheck(rv);
    end

    // Backpressure: result held for five cycles, a stray request is ignored.
    out_ready = 1'b0;
    applyStimulus(1'b0, 5'd7, 5'd9, 32'd0, 32'd16, lat);
    checkOutput("bp_latency", 32'(lat), 32'd13);
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      in_valid = (k == 2);
      in_result_lo = 32'd5;
      @(posedge clock);
      #1;
      checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
      checkOutput("bp_out_residue", 32'(out_residue), 32'd16);
      checkOutput("bp_out_expected", 32'(out_expected), 32'd16);
      checkOutput("bp_out_error", 32'(out_error), 32'd0);
      checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
    end
    @(negedge clock);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    checkOutput("bp_pop_out_valid", 32'(out_valid), 32'd0);
    checkOutput("bp_pop_in_ready", 32'(in_ready), 32'd1);
    repeat (3) @(posedge clock);
    #1;
    checkOutput("bp_stray_ignored", 32'(in_ready), 32'd1);

    // Reset during the sixth fold cycle discards the transaction.
    @(negedge clock);
    in_op        = 1'b0;
    in_a_res     = 5'd1;
    in_b_res     = 5'd2;
    in_result_hi = 32'd0;
    in_result_lo = 32'd3;
    in_valid     = 1'b1;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    checkOutput("rst_accepted", 32'(in_ready), 32'd0);
    repeat (5) @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("rst_async_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_async_out_valid", 32'(out_valid), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clock);
      #1;
      if (out_valid) seen++;
    end
    checkOutput("rst_no_out_valid", 32'(seen), 32'd0);
    checkOutput("rst_in_ready_after", 32'(in_ready), 32'd1);
    errModel = 0;
    runCheck(vecs[2]);
    runCheck(vecs[1]);

`ifdef RESCHK_ERR_COUNT_EN
    checkOutput("final_err_count", 32'(err_count), 32'(errModel));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
